// File: rtl/md5_iter_core.sv
// MD5 compression engine with ROUNDS_PER_CYCLE rounds unrolled per clock, final IV add and IV chaining.
// Optional target comparator enabled by defining MD5_TARGET_MATCH_EN (adds target/match ports).
module md5_iter_core #(
    parameter int ROUNDS_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] mesg,
    input  logic [127:0] iv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] digest,
    output logic         busy
`ifdef MD5_TARGET_MATCH_EN
    ,
    input  logic [127:0] target,
    output logic         match
`endif
);

    localparam int R = ROUNDS_PER_CYCLE;
    localparam logic [5:0] LAST_RND = 6'(64 - R);
    localparam logic [5:0] RND_STEP = 6'(R);

    if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16)) begin : g_bad_rounds
        $error("md5_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam logic [31:0] K_TAB [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Shift amounts indexed by {round group, round mod 4}.
    localparam logic [4:0] S_TAB [16] = '{
        5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21
    };

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
        return (x << s) | (x >> (6'd32 - {1'b0, s}));
    endfunction

    function automatic logic [31:0] md5_f(input logic [5:0] g, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
        case (g[5:4])
            2'd0:    return (b & c) | (~b & d);
            2'd1:    return (d & b) | (~d & c);
            2'd2:    return b ^ c ^ d;
            default: return c ^ (b | ~d);
        endcase
    endfunction

    function automatic logic [3:0] msg_idx(input logic [5:0] g);
        logic [3:0] n;
        n = g[3:0];
        case (g[5:4])
            2'd0:    return n;
            2'd1:    return n * 4'd5 + 4'd1;
            2'd2:    return n * 4'd3 + 4'd5;
            default: return n * 4'd7;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic   [5:0]  rnd_q;
    logic   [31:0] a_q, b_q, c_q, d_q;
    logic   [31:0] a_n, b_n, c_n, d_n;
    logic   [31:0] m_q [16];
    logic   [127:0] iv_q;
    logic   [127:0] final_sum;
    logic   [5:0]  rg;
    logic   [31:0] rf, rt;
    logic          accept, last_rnd;

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign last_rnd  = (rnd_q == LAST_RND);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last_rnd) state_d = DONE;
            DONE:    if (out_ready) state_d = in_valid ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // R chained rounds; blocking temporaries carry each round into the next.
    always_comb begin
        a_n = a_q;
        b_n = b_q;
        c_n = c_q;
        d_n = d_q;
        rg  = '0;
        rf  = '0;
        rt  = '0;
        for (int i = 0; i < R; i++) begin
            rg  = rnd_q + 6'(i);
            rf  = md5_f(rg, b_n, c_n, d_n);
            rt  = a_n + rf + K_TAB[rg] + m_q[msg_idx(rg)];
            a_n = d_n;
            d_n = c_n;
            c_n = b_n;
            b_n = b_n + rotl(rt, S_TAB[{rg[5:4], rg[1:0]}]);
        end
    end

    assign final_sum = {a_n + iv_q[127:96], b_n + iv_q[95:64],
                        c_n + iv_q[63:32],  d_n + iv_q[31:0]};

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: the block buffer and IV copy are pure data, always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < 16; j++) m_q[j] <= bswap(mesg[32*(15-j) +: 32]);
            iv_q <= iv;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            d_q    <= '0;
            rnd_q  <= '0;
            digest <= '0;
`ifdef MD5_TARGET_MATCH_EN
            match  <= 1'b0;
`endif
        end else if (accept) begin
            {a_q, b_q, c_q, d_q} <= iv;
            rnd_q <= '0;
        end else if (state_q == RUN) begin
            a_q   <= a_n;
            b_q   <= b_n;
            c_q   <= c_n;
            d_q   <= d_n;
            rnd_q <= rnd_q + RND_STEP;
            if (last_rnd) begin
                digest <= final_sum;
`ifdef MD5_TARGET_MATCH_EN
                match  <= (final_sum == target);
`endif
            end
        end
    end

endmodule

// File: tb/tb_md5_iter_core.sv
// Scoreboard bench for md5_iter_core: R=4 main instance plus R=1/2/8/16 instances for latency sweep.
// Honours MD5_TARGET_MATCH_EN when defined.
module tb_md5_iter_core;

    localparam logic [127:0] IV_STD    = 128'h67452301_efcdab89_98badcfe_10325476;
    localparam logic [127:0] DIG_EMPTY = 128'hd98c1dd4_04b2008f_980980e9_7e42f8ec;
    localparam logic [127:0] DIG_ABC   = 128'h98500190_b04fd23c_7d3f96d6_727fe128;
    localparam logic [511:0] MSG_EMPTY = {8'h80, 504'd0};
    localparam logic [511:0] MSG_ABC   = {32'h61626380, 416'd0, 8'h18, 56'd0};
    localparam int NX = 4;
    localparam int RX [NX] = '{1, 2, 8, 16};

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [511:0] mesg;
    logic [127:0] iv, digest;
    logic         in_valid_x, out_ready_x;
    logic         in_ready_x [NX];
    logic         out_valid_x [NX];
    logic         busy_x [NX];
    logic [127:0] digest_x [NX];
`ifdef MD5_TARGET_MATCH_EN
    logic [127:0] target;
    logic         match;
    logic         match_x [NX];
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [127:0] exp_q [$];
    logic         exp_m_q [$];
    int           acc_q [$];
    int           out_cyc_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    md5_iter_core #(.ROUNDS_PER_CYCLE(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .mesg(mesg), .iv(iv), .out_valid(out_valid), .out_ready(out_ready),
        .digest(digest), .busy(busy)
`ifdef MD5_TARGET_MATCH_EN
        , .target(target), .match(match)
`endif
    );

    for (genvar gi = 0; gi < NX; gi++) begin : g_xr
        md5_iter_core #(.ROUNDS_PER_CYCLE(RX[gi])) u_dut (
            .clk(clk), .reset(reset), .in_valid(in_valid_x), .in_ready(in_ready_x[gi]),
            .mesg(mesg), .iv(iv), .out_valid(out_valid_x[gi]), .out_ready(out_ready_x),
            .digest(digest_x[gi]), .busy(busy_x[gi])
`ifdef MD5_TARGET_MATCH_EN
            , .target(target), .match(match_x[gi])
`endif
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1: holds the block until accepted, then records expectations.
    task automatic send(input logic [511:0] msg, input logic [127:0] exp);
        int w = 0;
        in_valid = 1'b1;
        mesg     = msg;
        iv       = IV_STD;
        @(negedge clk);
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check("accept_timeout", 128'd0, 128'd1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(exp);
        exp_m_q.push_back(exp == DIG_ABC);
        acc_q.push_back(cyc + 1);
        tick();
        in_valid = 1'b0;
        mesg     = {16{$urandom()}};
        iv       = {4{$urandom()}};
    endtask

    task automatic wait_ov();
        int w = 0;
        while (!out_valid && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid) check("out_valid_timeout", 128'd0, 128'd1);
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("drain", 128'(exp_q.size()), 128'd0);
    endtask

    // Output monitor: latency on the first out_valid cycle, digest on handshake.
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            prev_ov <= 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                out_cyc_q.push_back(cyc);
                if (acc_q.size() == 0) check("unexpected_out", 128'd1, 128'd0);
                else                   check("latency", 128'(cyc - acc_q[0]), 128'd16);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_digest", 128'd1, 128'd0);
                end else begin
                    check("digest", digest, exp_q.pop_front());
                    void'(acc_q.pop_front());
`ifdef MD5_TARGET_MATCH_EN
                    check("match", 128'(match), 128'(exp_m_q[0]));
`endif
                    void'(exp_m_q.pop_front());
                end
            end
            prev_ov <= out_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc_x;
        int  n0;
        logic seen [NX];
        in_valid    = 1'b0;
        in_valid_x  = 1'b0;
        out_ready   = 1'b1;
        out_ready_x = 1'b0;
        mesg        = '0;
        iv          = IV_STD;
`ifdef MD5_TARGET_MATCH_EN
        target      = DIG_ABC;
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_digest", digest, 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
`ifdef MD5_TARGET_MATCH_EN
        check("rst_match", 128'(match), 128'd0);
`endif
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 128'(in_ready), 128'd1);

        // Empty string, R=4
        tick();
        send(MSG_EMPTY, DIG_EMPTY);
        drain();
        tick();
        @(negedge clk);
        check("idle_keeps_digest", digest, DIG_EMPTY);
        check("idle_out_valid", 128'(out_valid), 128'd0);

        // "abc" latency sweep over R=1,2,8,16
        tick();
        mesg = MSG_ABC;
        iv   = IV_STD;
        in_valid_x = 1'b1;
        @(negedge clk);
        acc_x = cyc + 1;
        tick();
        in_valid_x = 1'b0;
        for (int k = 0; k < NX; k++) seen[k] = 1'b0;
        for (int w = 0; w < 80; w++) begin
            @(negedge clk);
            for (int k = 0; k < NX; k++) begin
                if (out_valid_x[k] && !seen[k]) begin
                    seen[k] = 1'b1;
                    check($sformatf("latency_r%0d", RX[k]), 128'(cyc - acc_x), 128'(64 / RX[k]));
                    check($sformatf("digest_r%0d", RX[k]), digest_x[k], DIG_ABC);
                end
            end
        end
        for (int k = 0; k < NX; k++)
            if (!seen[k]) check($sformatf("timeout_r%0d", RX[k]), 128'd0, 128'd1);
        tick();
        out_ready_x = 1'b1;
        tick();
        @(negedge clk);
        for (int k = 0; k < NX; k++)
            check($sformatf("released_r%0d", RX[k]), 128'(out_valid_x[k]), 128'd0);

        // Backpressure, then same-edge handoff and accept
        tick();
        out_ready = 1'b0;
        send(MSG_ABC, DIG_ABC);
        wait_ov();
        tick();
        in_valid = 1'b1;
        mesg     = MSG_EMPTY;
        iv       = IV_STD;
        repeat (20) begin
            @(negedge clk);
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_in_ready", 128'(in_ready), 128'd0);
            check("bp_digest", digest, DIG_ABC);
        end
        tick();
        out_ready = 1'b1;
        send(MSG_EMPTY, DIG_EMPTY);
        @(negedge clk);
        check("handoff_out_valid", 128'(out_valid), 128'd0);
        check("handoff_busy", 128'(busy), 128'd1);
        drain();

        // Back-to-back stream of 8 alternating blocks
        tick();
        n0 = out_cyc_q.size();
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) send(MSG_EMPTY, DIG_EMPTY);
            else            send(MSG_ABC, DIG_ABC);
        end
        drain();
        check("stream_count", 128'(out_cyc_q.size() - n0), 128'd8);
        for (int i = 1; i < 8; i++)
            if (n0 + i < out_cyc_q.size())
                check("stream_spacing", 128'(out_cyc_q[n0+i] - out_cyc_q[n0+i-1]), 128'd17);
        tick();
        @(negedge clk);
        check("stream_last_digest", digest, DIG_ABC);
        check("stream_idle_ready", 128'(in_ready), 128'd1);

        // Asynchronous reset mid-RUN
        tick();
        send(MSG_ABC, DIG_ABC);
        repeat (5) @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_digest", digest, 128'd0);
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_in_ready", 128'(in_ready), 128'd1);
`ifdef MD5_TARGET_MATCH_EN
        check("midrst_match", 128'(match), 128'd0);
`endif
        exp_q.delete();
        exp_m_q.delete();
        acc_q.delete();
        tick();
        reset = 1'b1;
        tick();
        send(MSG_ABC, DIG_ABC);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
